// File: rtl/flot_square_seq_if.sv
// Operand/result handshake bundle for the sequential floating-point squarer.
interface flot_square_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] OP;
  logic             exce_in;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             exce_out;

  modport master (
    output in_valid, OP, exce_in,
    input  in_ready, out_valid, result, exce_out
  );

  modport slave (
    input  in_valid, OP, exce_in,
    output in_ready, out_valid, result, exce_out
  );
endinterface

// File: rtl/flot_square_seq.sv
// Multi-cycle floating-point squarer: one shift-add step per significand bit.
// Optional macro FLOT_SQUARE_ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module flot_square_seq #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned WIDTH_exp = 8,
  parameter int unsigned WIDTH_mat = 23
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           CE,
  flot_square_seq_if.slave bus
);

  localparam int unsigned SIG_W    = WIDTH_mat + 1;
  localparam int unsigned PROD_W   = 2 * SIG_W;
  localparam int unsigned EXP2_W   = WIDTH_exp + 2;
  localparam int unsigned CNT_W    = $clog2(SIG_W + 1);
  localparam int unsigned BIAS     = (1 << (WIDTH_exp - 1)) - 1;
  localparam int unsigned EXP_ONES = (1 << WIDTH_exp) - 1;
  localparam logic [WIDTH-1:0] INF_RES = {1'b0, {WIDTH_exp{1'b1}}, {WIDTH_mat{1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [SIG_W-1:0]     sig;
  logic [PROD_W-1:0]    prod;
  logic [WIDTH_exp-1:0] exp_q;
  logic                 exce_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     result_q;
  logic                 exce_out_q;

  logic [SIG_W:0]              step_sum;
  logic [PROD_W-1:0]           step_prod;
  logic                        hi;
  logic [WIDTH_mat-1:0]        mant;
  logic [WIDTH_mat-1:0]        mant_fin;
  logic signed [EXP2_W-1:0]    e2;
  logic [WIDTH-1:0]            res_n;
  logic                        exce_n;
`ifdef FLOT_SQUARE_ROUND_NEAREST_EN
  logic                        guard;
  logic                        sticky;
  logic [WIDTH_mat:0]          mant_rnd;
`endif

  // Shift-add step: the multiplier occupies the low half of prod and is consumed LSB first.
  always_comb begin : step
    step_sum  = {1'b0, prod[PROD_W-1:SIG_W]} + (prod[0] ? {1'b0, sig} : '0);
    step_prod = {step_sum, prod[SIG_W-1:1]};
  end

  // Normalise, round and resolve special cases from the finished product.
  always_comb begin : norm_round
    hi   = prod[PROD_W-1];
    mant = hi ? prod[PROD_W-2 -: WIDTH_mat] : prod[PROD_W-3 -: WIDTH_mat];
    e2   = $signed(EXP2_W'({exp_q, 1'b0})) - $signed(EXP2_W'(BIAS));
    if (hi) e2 = e2 + $signed(EXP2_W'(1));
`ifdef FLOT_SQUARE_ROUND_NEAREST_EN
    guard    = hi ? prod[PROD_W-2-WIDTH_mat] : prod[PROD_W-3-WIDTH_mat];
    sticky   = hi ? |prod[PROD_W-3-WIDTH_mat:0] : |prod[PROD_W-4-WIDTH_mat:0];
    mant_rnd = {1'b0, mant} + (WIDTH_mat+1)'(guard & (sticky | mant[0]));
    mant_fin = mant_rnd[WIDTH_mat-1:0];
    // A carry out means the significand rounded up to 2.0; the fraction is already zero.
    if (mant_rnd[WIDTH_mat]) e2 = e2 + $signed(EXP2_W'(1));
`else
    mant_fin = mant;
`endif
    res_n  = '0;
    exce_n = 1'b0;
    if (exce_q) begin
      exce_n = 1'b1;
    end else if (&exp_q) begin
      res_n  = INF_RES;
      exce_n = 1'b1;
    end else if (exp_q == '0) begin
      res_n = '0;
    end else if (e2 >= $signed(EXP2_W'(EXP_ONES))) begin
      res_n  = INF_RES;
      exce_n = 1'b1;
    end else if (e2 <= $signed(EXP2_W'(0))) begin
      res_n = '0;
    end else begin
      res_n = {1'b0, e2[WIDTH_exp-1:0], mant_fin};
    end
  end

  // Control FSM and all registered outputs; CE low freezes everything.
  always_ff @(posedge CLK or posedge RST) begin : fsm
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      sig         <= '0;
      prod        <= '0;
      exp_q       <= '0;
      exce_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      exce_out_q  <= 1'b0;
    end else if (CE) begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            sig        <= {1'b1, bus.OP[WIDTH_mat-1:0]};
            prod       <= {SIG_W'(0), 1'b1, bus.OP[WIDTH_mat-1:0]};
            exp_q      <= bus.OP[WIDTH-2 -: WIDTH_exp];
            exce_q     <= bus.exce_in;
            cnt        <= CNT_W'(SIG_W);
            in_ready_q <= 1'b0;
            state      <= CALC;
          end
        end
        CALC: begin
          if (cnt == '0) begin
            state <= NORM;
          end else begin
            prod <= step_prod;
            cnt  <= cnt - CNT_W'(1);
          end
        end
        NORM: begin
          result_q    <= res_n;
          exce_out_q  <= exce_n;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.exce_out  = exce_out_q;

endmodule
